// File: rtl/mult_acc_pkg.sv
// Shared types and sizing for the mult_acc dot-product sequencer.
// Holds the state encoding, datapath widths and the product widening helper.
package mult_acc_pkg;

  localparam int ACC_W   = 20;
  localparam int LEN_W   = 4;
  localparam int OP_W    = 8;
  localparam int PROD_W  = 2 * OP_W;
  localparam int TMO_MAX = 31;
  localparam int TMO_W   = 5;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    ISSUE,
    WAIT_HI,
    WAIT_LO,
    DONE
  } state_t;

  // The 16-bit product is zero-extended into the accumulator; 15 full-scale
  // products still fit in 20 bits, so no carry or saturation handling exists.
  function automatic logic [ACC_W-1:0] extend_product(input logic [PROD_W-1:0] p);
    return {{(ACC_W - PROD_W){1'b0}}, p};
  endfunction

endpackage

// File: rtl/mult_acc_if.sv
// Operand stream and multiplier bus of mult_acc, bundled as one interface.
// The slave modport is the mult_acc side; master is the surrounding environment.
interface mult_acc_if;
  import mult_acc_pkg::*;

  logic              op_valid;
  logic              op_ready;
  logic [OP_W-1:0]   a_in;
  logic [OP_W-1:0]   b_in;

  logic              mul_start;
  logic [OP_W-1:0]   mul_a;
  logic [OP_W-1:0]   mul_b;
  logic              mul_busy;
  logic [PROD_W-1:0] mul_product;

  modport slave (
    input  op_valid,
    input  a_in,
    input  b_in,
    output op_ready,
    output mul_start,
    output mul_a,
    output mul_b,
    input  mul_busy,
    input  mul_product
  );

  modport master (
    output op_valid,
    output a_in,
    output b_in,
    input  op_ready,
    input  mul_start,
    input  mul_a,
    input  mul_b,
    output mul_busy,
    output mul_product
  );

endinterface

// File: rtl/mult_acc.sv
// Dot-product sequencer: feeds operand pairs to an external shift-add multiplier
// and sums the products. Optional watchdog enabled by MULT_ACC_TIMEOUT_EN.
module mult_acc
  import mult_acc_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  mult_acc_if.slave        bus,
  output logic             busy,
  output logic             done,
  output logic [ACC_W-1:0] acc,
  output logic             err
);

  state_t           state;
  logic [LEN_W-1:0] remaining;

`ifdef MULT_ACC_TIMEOUT_EN
  logic [TMO_W-1:0] wd;
  logic             wd_expired;

  // wd holds the number of wait cycles already completed, so the 31st wait
  // cycle is the one that sees TMO_MAX-1 and aborts.
  assign wd_expired = (wd == TMO_W'(TMO_MAX - 1));
`else
  assign err = 1'b0;
`endif

  // All outputs are registered and set on the transition into the state that owns them.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      remaining     <= '0;
      acc           <= '0;
      bus.mul_a     <= '0;
      bus.mul_b     <= '0;
      bus.op_ready  <= 1'b0;
      bus.mul_start <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
`ifdef MULT_ACC_TIMEOUT_EN
      err           <= 1'b0;
      wd            <= '0;
`endif
    end else begin
      bus.mul_start <= 1'b0;
      done          <= 1'b0;
`ifdef MULT_ACC_TIMEOUT_EN
      err           <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (start) begin
            acc  <= '0;
            busy <= 1'b1;
            if (len != '0) begin
              remaining    <= len;
              bus.op_ready <= 1'b1;
              state        <= FETCH;
            end else begin
              done  <= 1'b1;
              state <= DONE;
            end
          end
        end

        FETCH: begin
          if (bus.op_valid && bus.op_ready) begin
            bus.mul_a     <= bus.a_in;
            bus.mul_b     <= bus.b_in;
            bus.op_ready  <= 1'b0;
            bus.mul_start <= 1'b1;
            state         <= ISSUE;
`ifdef MULT_ACC_TIMEOUT_EN
            wd            <= '0;
`endif
          end
        end

        ISSUE: begin
          state <= WAIT_HI;
        end

        WAIT_HI: begin
          if (bus.mul_busy) begin
            state <= WAIT_LO;
          end
`ifdef MULT_ACC_TIMEOUT_EN
          else if (wd_expired) begin
            done  <= 1'b1;
            err   <= 1'b1;
            state <= DONE;
          end
          wd <= wd + 1'b1;
`endif
        end

        WAIT_LO: begin
          if (!bus.mul_busy) begin
            acc       <= acc + extend_product(bus.mul_product);
            remaining <= remaining - 1'b1;
            if (remaining > LEN_W'(1)) begin
              bus.op_ready <= 1'b1;
              state        <= FETCH;
            end else begin
              done  <= 1'b1;
              state <= DONE;
            end
          end
`ifdef MULT_ACC_TIMEOUT_EN
          else if (wd_expired) begin
            done  <= 1'b1;
            err   <= 1'b1;
            state <= DONE;
          end
          wd <= wd + 1'b1;
`endif
        end

        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          busy         <= 1'b0;
          bus.op_ready <= 1'b0;
          state        <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/mult_acc.md
MULT_ACC -- requirements
Module: mult_acc

Interface
REQ-001 clk  input  1  single clock; all state changes on its rising edge.
REQ-002 reset  input  1  asynchronous, active-low reset (reset=0 clears all state immediately).
REQ-003 start  input  1  begin one dot-product job; sampled only in IDLE.
REQ-004 len  input  4  number of operand pairs in the job; latched on accepted start.
REQ-005 op_valid  input  1  operand pair a_in/b_in is present.
REQ-006 op_ready  output  1  block accepts a pair this cycle.
REQ-007 a_in, b_in  input  8 each  unsigned operand pair.
REQ-008 mul_start  output  1  one-cycle start pulse to the downstream shift-add multiplier.
REQ-009 mul_a, mul_b  output  8 each  registered operands presented to the multiplier, stable from mul_start until the product is captured.
REQ-010 mul_busy  input  1  multiplier busy flag; rises the cycle after mul_start is sampled, falls when its product register is valid.
REQ-011 mul_product  input  16  multiplier result.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 done  output  1  one-cycle pulse when the job ends.
REQ-014 acc  output  20  unsigned sum of products; holds its value until the next accepted start.
REQ-015 err  output  1  one-cycle pulse with done on timeout abort; tied 0 when the timeout feature is absent.

Function
REQ-016 States: IDLE, FETCH, ISSUE, WAIT_HI, WAIT_LO, DONE.
- IDLE -> FETCH on start with len!=0: clear acc, load remaining=len.
- IDLE -> DONE on start with len==0: acc=0.
REQ-017 FETCH: op_ready=1. On op_valid&&op_ready, register a_in/b_in into mul_a/mul_b -> ISSUE. With op_valid low, stay in FETCH indefinitely.
REQ-018 ISSUE: mul_start=1 for exactly one cycle -> WAIT_HI.
REQ-019 WAIT_HI: wait for mul_busy=1 -> WAIT_LO.
REQ-020 WAIT_LO: on mul_busy=0, acc<=acc+mul_product (zero-extended to 20 bits) and remaining<=remaining-1; -> FETCH if remaining>1, else -> DONE.
REQ-021 DONE: done=1 for one cycle -> IDLE. acc is final in the same cycle done is high.
REQ-022 Arithmetic: 20-bit accumulator, no overflow possible (15*255*255=975375 < 2^20); no saturation logic.
REQ-023 Outside IDLE, start is ignored; len changes after acceptance have no effect.
REQ-024 op_ready=0 in all states except FETCH. mul_start=0 in all states except ISSUE.

Reset
REQ-025 While reset=0:
- state=IDLE;
- acc=0, mul_a=0, mul_b=0, remaining=0;
- op_ready, mul_start, busy, done and err are all 0.
REQ-026 Reset asserted mid-job aborts the job with no done pulse. The first start after release begins a fresh job.

Configuration
REQ-027 Macro MULT_ACC_TIMEOUT_EN defined: a 5-bit watchdog counts cycles spent in WAIT_HI+WAIT_LO for the current pair and clears on entry to ISSUE. On reaching 31 -> DONE with err=1; acc keeps the partial sum. Undefined: no watchdog, err constant 0, WAIT states wait indefinitely.

Structure
REQ-028 Shared package mult_acc_pkg holds:
- state encoding typedef;
- ACC_W=20, LEN_W=4, OP_W=8, TMO_MAX=31.
REQ-029 No sub-module: the multiplier is instantiated alongside by the parent, and mult_acc connects only through the mul_* ports.

Verification
REQ-030 start, len=1, pair (3,4) -> one mul_start pulse; done pulse with acc=12; busy low the following cycle.
REQ-031 len=3, pairs (255,255),(1,1),(10,20) -> acc=65226 at done; exactly 3 mul_start pulses.
REQ-032 len=0 -> done within 2 cycles of start, acc=0, no mul_start.
REQ-033 op_valid held low for 20 cycles in FETCH -> op_ready stays 1, no mul_start; the job completes normally once op_valid rises.
REQ-034 reset=0 pulsed during WAIT_LO of pair 2 -> all outputs 0 immediately and no done pulse; a new job with (2,2) gives acc=4.
REQ-035 With MULT_ACC_TIMEOUT_EN: model holds mul_busy high indefinitely -> done=1 and err=1 in the same cycle, 31 cycles after WAIT_HI entry, acc=partial sum; without the macro, busy stays high.
